mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be: DEPTH, default 256, number of 32-bit words in the storage array (power of two, 2..4096).
REQ-002 LATENCY, default 2, wait cycles between request acceptance and ack (0..15).
REQ-003 Ports SHALL be, in this order:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  1  request from initiator/mux; held high until ack seen.
- addr  input  32  byte address; word index = addr[log2(DEPTH)+1:2].
- cmd  input  1  0 = read, 1 = write.
- wdata  input  32  write data.
- ack  output  1  registered one-cycle completion pulse.
- rdata  output  32  registered read data; valid in the ack cycle of a read.
- busy  output  1  registered; high from acceptance through the ack cycle.

Function
REQ-004 The block SHALL implement the responder end of the req/addr/cmd/wdata -> ack/rdata protocol driven by the two-to-one slave mux.
REQ-005 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-006 IDLE: when req=1 at a rising edge, the block SHALL capture addr index, cmd and wdata, load the wait counter with LATENCY, and go to WAIT; if LATENCY=0 it SHALL go directly to RESP.
REQ-007 WAIT: the counter SHALL decrement by 1 per cycle, and the FSM SHALL go to RESP at the edge where the counter is 1.
REQ-008 Latency: for a request first sampled at edge t, ack SHALL be high exactly in the cycle following edge t+LATENCY.
REQ-009 Write access: on the edge entering RESP with cmd=1, mem[index] SHALL take the captured wdata; rdata is unchanged.
REQ-010 Read access: on the edge entering RESP with cmd=0, rdata SHALL take mem[index].
REQ-011 A write followed by a read of the same index SHALL return the written value.
REQ-012 RESP: ack=1 for exactly one cycle, after which the FSM SHALL return unconditionally to IDLE.
REQ-013 req sampled at the edge ending the ack cycle SHALL be ignored, so the minimum request spacing is one idle cycle.
REQ-014 Changes on addr, cmd or wdata after acceptance SHALL have no effect on the transaction in progress.
REQ-015 If req drops during WAIT, the transaction SHALL still complete and ack SHALL still pulse.
REQ-016 Address bits above the index and addr[1:0] SHALL be ignored, so addresses alias modulo DEPTH words; no error is signalled.
REQ-017 rdata SHALL hold its last read value between read acks.
REQ-018 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.

Reset
REQ-019 While rst=1 at an edge, the FSM SHALL go to IDLE and ack, busy and rdata SHALL be 0; req SHALL be ignored.
REQ-020 Reset during WAIT SHALL abort the transaction: no memory write and no ack.
REQ-021 Storage contents SHALL NOT be reset.
REQ-022 The first request SHALL be acceptable at the first edge with rst=0.

Verification
REQ-023 LATENCY=2: write addr=0x10, wdata=0xDEADBEEF, req at edge t -> ack high only in the cycle after t+2, busy high for 3 cycles; then read addr=0x10 -> rdata=0xDEADBEEF during ack.
REQ-024 LATENCY=0: read after write of 0x12345678 to addr=0x4 -> ack in the cycle immediately after acceptance, rdata=0x12345678.
REQ-025 req held high continuously over 3 reads (addr 0x0, 0x4, 0x8, with the initiator updating addr after each ack) -> acks spaced LATENCY+2 cycles apart, with one idle cycle between transactions.
REQ-026 Accept a write of 0xAAAA5555 to addr=0x20, then change wdata to 0 during WAIT and drop req -> ack still pulses, and a later read of 0x20 returns 0xAAAA5555.
REQ-027 DEPTH=256: write 0x1 to addr=0x400, then read addr=0x0 -> returns 0x1 (alias).
REQ-028 Start a write of 0xFFFFFFFF to an index previously holding 0x5, then assert rst during WAIT -> no ack, busy=0 and rdata=0 next cycle, and a read of that index returns 0x5.

Source files
------------

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Responder end of the req/addr/cmd/wdata -> ack/rdata protocol driven by the
// two-to-one slave mux. The block accepts one request at a time into a
// DEPTH x 32-bit storage array. It waits LATENCY cycles, performs the access,
// and then pulses ack for one cycle.
//
// Handshake: the initiator raises req and holds addr/cmd/wdata until it sees
// ack. The request is accepted at the first rising edge where req=1 and the
// FSM is IDLE. Everything needed for the access is captured at that edge, so
// later changes on addr/cmd/wdata, or a drop of req, do not affect the
// transaction. The access happens on the edge entering RESP, and ack is high
// in the cycle that follows. The edge that ends the ack cycle always returns to
// IDLE without sampling req, so back-to-back requests are separated by one
// idle cycle.
//
// Parameters:
//   DEPTH    number of 32-bit words (power of two, 2..4096)
//   LATENCY  wait cycles between acceptance and ack (0..15)
//
// Ports:
//   clk    in   1   single clock, rising edge
//   rst    in   1   synchronous, active-high reset
//   req    in   1   request, held high until ack
//   addr   in  32   byte address; word index = addr[log2(DEPTH)+1:2]
//   cmd    in   1   0 = read, 1 = write
//   wdata  in  32   write data
//   ack    out  1   registered one-cycle completion pulse
//   rdata  out 32   registered read data, valid in the ack cycle of a read
//   busy   out  1   registered, high from acceptance through the ack cycle
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        cmd,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] LAT = 4'(LATENCY);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          cmd_q, cmd_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          ack_q, busy_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          enter_resp;

  logic [31:0]   mem_q [DEPTH];

  // Address bits outside the word index are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:IW+2], addr[1:0]};

  // Next-state logic. idx_d/cmd_d/wdata_d always hold the operands of the
  // access that happens when enter_resp is set. At acceptance they are the
  // live inputs, which the LATENCY=0 path needs. Otherwise they are the
  // captured copies.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    cmd_d      = cmd_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          idx_d   = addr[IW+1:2];
          cmd_d   = cmd;
          wdata_d = wdata;
          cnt_d   = LAT;
          if (LAT == 4'd0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        // req is not looked at here: this forces the idle gap.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // rdata only changes on the edge entering RESP for a read. Between reads it
  // keeps its last value.
  always_comb begin
    rdata_d = rdata_q;
    if (enter_resp && !cmd_d) begin
      rdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      cmd_q   <= 1'b0;
      wdata_q <= 32'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      wdata_q <= wdata_d;
      ack_q   <= (state_d == S_RESP);
      busy_q  <= (state_d != S_IDLE);
      rdata_q <= rdata_d;
    end
  end

  // The storage array is not reset. A reset that lands on the would-be RESP
  // edge suppresses the write, so an aborted transaction leaves no trace.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cmd_d) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign ack   = ack_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Directed bench for mem_responder. Instance 0 uses DEPTH=256, LATENCY=2.
// Instance 1 uses DEPTH=256, LATENCY=0. All expected values are hand-computed
// constants. Inputs are driven and outputs are sampled 1ns after the rising
// edge.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  logic              clk;
  logic              rst;
  logic [1:0]        req_v;
  logic [1:0]        cmd_v;
  logic [1:0][31:0]  addr_v;
  logic [1:0][31:0]  wdata_v;
  logic [1:0]        ack_v;
  logic [1:0]        busy_v;
  logic [1:0][31:0]  rdata_v;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_lat2 (
    .clk   (clk),
    .rst   (rst),
    .req   (req_v[0]),
    .addr  (addr_v[0]),
    .cmd   (cmd_v[0]),
    .wdata (wdata_v[0]),
    .ack   (ack_v[0]),
    .rdata (rdata_v[0]),
    .busy  (busy_v[0])
  );

  mem_responder #(.DEPTH(256), .LATENCY(0)) u_dut_lat0 (
    .clk   (clk),
    .rst   (rst),
    .req   (req_v[1]),
    .addr  (addr_v[1]),
    .cmd   (cmd_v[1]),
    .wdata (wdata_v[1]),
    .ack   (ack_v[1]),
    .rdata (rdata_v[1]),
    .busy  (busy_v[1])
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Full transaction on instance s. It checks the ack latency, the rdata value
  // in the ack cycle, the busy cycle count and the single-cycle ack.
  task automatic txn(input int s, input logic c, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input string tag);
    int n;
    int bcnt;
    int lat;
    lat  = (s == 0) ? 2 : 0;
    n    = 0;
    bcnt = 0;
    req_v[s]   = 1'b1;
    cmd_v[s]   = c;
    addr_v[s]  = a;
    wdata_v[s] = wd;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy_v[s]) bcnt++;
    end while (!ack_v[s] && n < 40);
    check({tag, " ack latency"}, n, lat + 1);
    check({tag, " rdata"}, rdata_v[s], exp_rd);
    req_v[s] = 1'b0;
    @(posedge clk); #1;
    check({tag, " ack one cycle"}, 32'(ack_v[s]), 32'd0);
    check({tag, " busy low after"}, 32'(busy_v[s]), 32'd0);
    check({tag, " busy cycles"}, bcnt, lat + 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;

    // Reset with req held high; the request must be ignored.
    rst     = 1'b1;
    req_v   = 2'b11;
    cmd_v   = 2'b00;
    addr_v  = '0;
    wdata_v = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ack0",   32'(ack_v[0]),  32'd0);
    check("reset busy0",  32'(busy_v[0]), 32'd0);
    check("reset rdata0", rdata_v[0],     32'd0);
    check("reset ack1",   32'(ack_v[1]),  32'd0);
    check("reset busy1",  32'(busy_v[1]), 32'd0);
    check("reset rdata1", rdata_v[1],     32'd0);

    // The first request is accepted at the first edge with rst=0.
    rst   = 1'b0;
    req_v = 2'b00;
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        "wr10");
    txn(0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, "rd10");

    // LATENCY=0 instance.
    txn(1, 1'b1, 32'h4, 32'h12345678, 32'h0,        "l0 wr4");
    txn(1, 1'b0, 32'h4, 32'h0,        32'h12345678, "l0 rd4");

    // Inputs change and req drops during WAIT.
    req_v[0] = 1'b1; cmd_v[0] = 1'b1; addr_v[0] = 32'h20; wdata_v[0] = 32'hAAAA5555;
    @(posedge clk); #1;
    check("chg busy", 32'(busy_v[0]), 32'd1);
    req_v[0] = 1'b0; cmd_v[0] = 1'b0; addr_v[0] = 32'h24; wdata_v[0] = 32'h0;
    n = 0;
    while (!ack_v[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("chg ack latency", n, 2);
    check("chg rdata held", rdata_v[0], 32'hDEADBEEF);
    @(posedge clk); #1;
    check("chg busy low", 32'(busy_v[0]), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 32'hAAAA5555, "rd20");

    // Back-to-back reads with req held high.
    txn(0, 1'b1, 32'h0, 32'h11111111, 32'hAAAA5555, "wr0");
    txn(0, 1'b1, 32'h4, 32'h22222222, 32'hAAAA5555, "wr4");
    txn(0, 1'b1, 32'h8, 32'h33333333, 32'hAAAA5555, "wr8");
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h22222222);
    exp_q.push_back(32'h33333333);
    req_v[0] = 1'b1; cmd_v[0] = 1'b0; addr_v[0] = 32'h0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
        if (n == 1 && k > 0) check("b2b idle gap", 32'(busy_v[0]), 32'd0);
      end while (!ack_v[0] && n < 40);
      check("b2b spacing", n, (k == 0) ? 3 : 4);
      check("b2b rdata", rdata_v[0], exp_q.pop_front());
      addr_v[0] = 32'((k + 1) * 4);
    end
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    check("b2b busy low", 32'(busy_v[0]), 32'd0);

    // Aliasing modulo DEPTH words; addr[1:0] ignored.
    txn(0, 1'b1, 32'h400, 32'h1, 32'h33333333, "wr400");
    txn(0, 1'b0, 32'h0,   32'h0, 32'h1,        "alias rd0");
    txn(0, 1'b0, 32'h403, 32'h0, 32'h1,        "alias rd403");

    // Reset during WAIT aborts the write.
    txn(0, 1'b1, 32'h30, 32'h5, 32'h1, "wr30");
    req_v[0] = 1'b1; cmd_v[0] = 1'b1; addr_v[0] = 32'h30; wdata_v[0] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("abort busy", 32'(busy_v[0]), 32'd1);
    @(posedge clk); #1;
    check("abort no early ack", 32'(ack_v[0]), 32'd0);
    rst = 1'b1;
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    check("abort ack",   32'(ack_v[0]),  32'd0);
    check("abort busy0", 32'(busy_v[0]), 32'd0);
    check("abort rdata", rdata_v[0],     32'd0);
    rst = 1'b0;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_v[0]) n++;
    end
    check("abort ack count", n, 0);
    txn(0, 1'b0, 32'h30, 32'h0, 32'h5, "rd30 after abort");

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
